// File: rtl/xadc_drp_responder.sv
// DRP target with a 128x16 register file and an XADC-style channel sequencer,
// standing in for the hard XADC so on-die sensor pollers run unmodified.
module xadc_drp_responder #(
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned CONV_CYCLES  = 26
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        drp_en_i,
  input  logic        drp_we_i,
  input  logic [6:0]  drp_addr_i,
  input  logic [15:0] drp_din_i,
  output logic [15:0] drp_dout_o,
  output logic        drp_ready_o,
  output logic        drp_err_o,
  output logic        busy_o,
  output logic        eoc_o,
  output logic [4:0]  channel_o,
  input  logic [15:0] sample_temp_i,
  input  logic [15:0] sample_vccint_i,
  input  logic [15:0] sample_vccaux_i,
  input  logic [15:0] sample_vccbram_i,
  output logic        ot_o
);
  typedef enum logic {DRP_IDLE, DRP_WAIT} drpState_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_CONV, SEQ_EOC} seqState_e;

  localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY - 1);
  localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

  drpState_e   drpState_q, drpState_d;
  logic [3:0]  latCnt_q, latCnt_d;
  logic        reqWe_q, reqWe_d;
  logic [6:0]  reqAddr_q, reqAddr_d;
  logic [15:0] reqDin_q, reqDin_d;
  logic        drpErr_q, drpErr_d;
  logic        drpAck, drpWrite;

  seqState_e   seqState_q, seqState_d;
  logic [7:0]  convCnt_q, convCnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  chIdx_q, chIdx_d;
  logic        ot_q, ot_d;

  logic [15:0] regs_q [128];
  logic        seqRun, statusWrite;
  logic [3:0]  maskNow;
  logic [2:0]  nextAbove, firstNow;
  logic [4:0]  chanAddr;
  logic [15:0] statusData;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [2:0] pickFirst(input logic [3:0] m);
    pickFirst = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) pickFirst = {1'b1, 2'(i)};
    end
  endfunction

  function automatic logic [15:0] resetValue(input logic [6:0] a);
    case (a)
      7'h40:   resetValue = 16'h2000;
      7'h41:   resetValue = 16'h20F0;
      7'h42:   resetValue = 16'h0A00;
      7'h48:   resetValue = 16'h4701;
      7'h53:   resetValue = 16'hDDDD;
      7'h57:   resetValue = 16'hAE4E;
      default: resetValue = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drpState_q <= DRP_IDLE;
      latCnt_q   <= 4'd0;
      reqWe_q    <= 1'b0;
      reqAddr_q  <= 7'd0;
      reqDin_q   <= 16'd0;
      drpErr_q   <= 1'b0;
    end else begin
      drpState_q <= drpState_d;
      latCnt_q   <= latCnt_d;
      reqWe_q    <= reqWe_d;
      reqAddr_q  <= reqAddr_d;
      reqDin_q   <= reqDin_d;
      drpErr_q   <= drpErr_d;
    end
  end

  assign drpAck   = (drpState_q == DRP_WAIT) && (latCnt_q == 4'd0);
  assign drpWrite = drpAck && reqWe_q && reqAddr_q[6];

  // The ack cycle is also an accept window, so back-to-back requests never see an error.
  always_comb begin
    drpState_d = drpState_q;
    latCnt_d   = latCnt_q;
    reqWe_d    = reqWe_q;
    reqAddr_d  = reqAddr_q;
    reqDin_d   = reqDin_q;
    drpErr_d   = drpErr_q;
    if (drpState_q == DRP_IDLE || drpAck) begin
      drpState_d = drp_en_i ? DRP_WAIT : DRP_IDLE;
      if (drp_en_i) begin
        latCnt_d  = LAT_LOAD;
        reqWe_d   = drp_we_i;
        reqAddr_d = drp_addr_i;
        reqDin_d  = drp_din_i;
      end
    end else begin
      latCnt_d = latCnt_q - 4'd1;
      if (drp_en_i) drpErr_d = 1'b1;
    end
  end

  always_comb begin
    drp_ready_o = drpAck;
    drp_dout_o  = drpAck ? regs_q[reqAddr_q] : 16'h0000;
    drp_err_o   = drpErr_q;
  end

  assign seqRun    = (regs_q[7'h41][15:12] == 4'h2);
  assign maskNow   = {regs_q[7'h48][14], regs_q[7'h48][10:8]};
  assign nextAbove = pickFirst(mask_q & (4'b1110 << chIdx_q));
  assign firstNow  = pickFirst(maskNow);
  assign chanAddr  = (chIdx_q == 2'd3) ? 5'd6 : {3'b000, chIdx_q};

  always_comb begin
    case (chIdx_q)
      2'd0:    statusData = sample_temp_i & 16'hFFF0;
      2'd1:    statusData = sample_vccint_i & 16'hFFF0;
      2'd2:    statusData = sample_vccaux_i & 16'hFFF0;
      default: statusData = sample_vccbram_i & 16'hFFF0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seqState_q <= SEQ_IDLE;
      convCnt_q  <= 8'd0;
      mask_q     <= 4'd0;
      chIdx_q    <= 2'd0;
      ot_q       <= 1'b0;
    end else begin
      seqState_q <= seqState_d;
      convCnt_q  <= convCnt_d;
      mask_q     <= mask_d;
      chIdx_q    <= chIdx_d;
      ot_q       <= ot_d;
    end
  end

  // The enable mask is only re-sampled when a scan starts or wraps.
  always_comb begin
    seqState_d = seqState_q;
    convCnt_d  = convCnt_q;
    mask_d     = mask_q;
    chIdx_d    = chIdx_q;
    unique case (seqState_q)
      SEQ_IDLE: begin
        if (seqRun && firstNow[2]) begin
          seqState_d = SEQ_CONV;
          convCnt_d  = CONV_LOAD;
          mask_d     = maskNow;
          chIdx_d    = firstNow[1:0];
        end
      end
      SEQ_CONV: begin
        if (convCnt_q == 8'd0) seqState_d = SEQ_EOC;
        else convCnt_d = convCnt_q - 8'd1;
      end
      SEQ_EOC: begin
        seqState_d = SEQ_IDLE;
        if (seqRun && nextAbove[2]) begin
          seqState_d = SEQ_CONV;
          convCnt_d  = CONV_LOAD;
          chIdx_d    = nextAbove[1:0];
        end else if (seqRun && firstNow[2]) begin
          seqState_d = SEQ_CONV;
          convCnt_d  = CONV_LOAD;
          mask_d     = maskNow;
          chIdx_d    = firstNow[1:0];
        end
      end
      default: seqState_d = SEQ_IDLE;
    endcase
  end

  assign statusWrite = (seqState_q == SEQ_EOC);

  // Set wins over clear when the thresholds overlap.
  always_comb begin
    ot_d = ot_q;
    if (statusWrite && chIdx_q == 2'd0) begin
      if (statusData[15:4] >= regs_q[7'h53][15:4]) ot_d = 1'b1;
      else if (statusData[15:4] < regs_q[7'h57][15:4]) ot_d = 1'b0;
    end
  end

  always_comb begin
    busy_o    = (seqState_q == SEQ_CONV);
    eoc_o     = (seqState_q == SEQ_EOC);
    channel_o = chanAddr;
    ot_o      = ot_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 128; i++) regs_q[i] <= resetValue(7'(i));
    end else begin
      if (drpWrite) regs_q[reqAddr_q] <= reqDin_q;
      if (statusWrite) regs_q[{2'b00, chanAddr}] <= statusData;
    end
  end
endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder: timestamp-based reference model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_xadc_drp_responder;
  localparam int LAT  = 4;
  localparam int CONV = 26;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drp_en = 1'b0, drp_we = 1'b0;
  logic [6:0]  drp_addr = 7'd0;
  logic [15:0] drp_din = 16'd0;
  logic [15:0] drp_dout;
  logic        drp_ready, drp_err, busy, eoc, ot;
  logic [4:0]  channel;
  logic [15:0] sTemp = 16'd0, sVccint = 16'd0, sVccaux = 16'd0, sBram = 16'd0;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  xadc_drp_responder #(.READ_LATENCY(LAT), .CONV_CYCLES(CONV)) dut (
    .clk_i(clk), .rst_i(rst),
    .drp_en_i(drp_en), .drp_we_i(drp_we), .drp_addr_i(drp_addr), .drp_din_i(drp_din),
    .drp_dout_o(drp_dout), .drp_ready_o(drp_ready), .drp_err_o(drp_err),
    .busy_o(busy), .eoc_o(eoc), .channel_o(channel),
    .sample_temp_i(sTemp), .sample_vccint_i(sVccint),
    .sample_vccaux_i(sVccaux), .sample_vccbram_i(sBram),
    .ot_o(ot)
  );

  // Reference model: absolute cycle timestamps for DRP acks and conversion windows.
  logic [15:0] mRegs [128];
  bit          mPend = 1'b0, mWe = 1'b0, mErr = 1'b0, mOn = 1'b0, mOt = 1'b0;
  logic [6:0]  mAddr = 7'd0;
  logic [15:0] mDin = 16'd0;
  int          cyc = 0, mAckCyc = 0, mStart = 0, mChan = 0, mPos = 0;
  int          mList[$];

  function automatic logic [15:0] sampleFor(input int ch);
    case (ch)
      0:       return sTemp;
      1:       return sVccint;
      2:       return sVccaux;
      default: return sBram;
    endcase
  endfunction

  task automatic buildList();
    mList.delete();
    if (mRegs[7'h48][8])  mList.push_back(0);
    if (mRegs[7'h48][9])  mList.push_back(1);
    if (mRegs[7'h48][10]) mList.push_back(2);
    if (mRegs[7'h48][14]) mList.push_back(6);
  endtask

  always @(posedge clk) begin : model
    logic [15:0] sv;
    bit ackNow, runNow;
    if (rst) begin
      for (int i = 0; i < 128; i++) mRegs[i] = 16'h0000;
      mRegs[7'h40] = 16'h2000; mRegs[7'h41] = 16'h20F0; mRegs[7'h42] = 16'h0A00;
      mRegs[7'h48] = 16'h4701; mRegs[7'h53] = 16'hDDDD; mRegs[7'h57] = 16'hAE4E;
      mPend = 0; mErr = 0; mOn = 0; mOt = 0; mChan = 0; mPos = 0;
      mList.delete();
    end else begin
      ackNow = mPend && (cyc == mAckCyc);
      runNow = (mRegs[7'h41][15:12] == 4'h2);
      if (mOn && cyc == mStart + CONV) begin
        sv = sampleFor(mChan) & 16'hFFF0;
        if (mChan == 0) begin
          if (sv[15:4] >= mRegs[7'h53][15:4]) mOt = 1;
          else if (sv[15:4] < mRegs[7'h57][15:4]) mOt = 0;
        end
        mRegs[mChan] = sv;
        if (!runNow) mOn = 0;
        else begin
          mPos++;
          if (mPos >= mList.size()) begin
            buildList();
            mPos = 0;
          end
          if (mList.size() == 0) mOn = 0;
          else begin
            mChan = mList[mPos];
            mStart = cyc + 1;
          end
        end
      end else if (!mOn && runNow) begin
        buildList();
        if (mList.size() != 0) begin
          mOn = 1; mPos = 0; mChan = mList[0]; mStart = cyc + 1;
        end
      end
      if (ackNow) begin
        if (mWe && mAddr >= 7'h40) mRegs[mAddr] = mDin;
        mPend = 0;
      end
      if (drp_en) begin
        if (mPend) mErr = 1;
        else begin
          mPend = 1; mWe = drp_we; mAddr = drp_addr; mDin = drp_din;
          mAckCyc = cyc + LAT;
        end
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit          exReady, exBusy, exEoc;
  logic [15:0] exDout;
  always @(negedge clk) begin
    if (checkEn) begin
      exReady = mPend && (cyc == mAckCyc);
      exDout  = exReady ? mRegs[mAddr] : 16'h0000;
      exBusy  = mOn && (cyc >= mStart) && (cyc < mStart + CONV);
      exEoc   = mOn && (cyc == mStart + CONV);
      checkOutput("drp_ready", drp_ready, exReady);
      checkOutput("drp_dout", drp_dout, exDout);
      checkOutput("drp_err", drp_err, mErr);
      checkOutput("busy", busy, exBusy);
      checkOutput("eoc", eoc, exEoc);
      checkOutput("channel", channel, mChan[4:0]);
      checkOutput("ot", ot, mOt);
    end
  end

  // One DRP transaction; returns read data and cycles from drp_en to drp_ready (99 on timeout).
  task automatic applyStimulus(input logic we, input logic [6:0] a, input logic [15:0] d,
                               output logic [15:0] rd, output int lat);
    @(negedge clk);
    drp_en = 1'b1; drp_we = we; drp_addr = a; drp_din = d;
    @(negedge clk);
    drp_en = 1'b0;
    lat = 1;
    while (!drp_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = drp_dout;
    if (!drp_ready) lat = 99;
  endtask

  task automatic waitEoc(input int ch, output int got);
    int n;
    n = 0;
    got = -1;
    do begin
      @(negedge clk);
      n++;
      if (eoc && (ch < 0 || int'(channel) == ch)) got = int'(channel);
    end while (got < 0 && n < 400);
  endtask

  initial begin
    logic [15:0] rd;
    int lat, got, n, cnt;
    int expOrder[5];
    int expAfter[4];
    expOrder = '{0, 1, 2, 6, 0};
    expAfter = '{2, 6, 0, 2};
    sTemp = 16'h1234; sVccint = 16'h1111; sVccaux = 16'h2222; sBram = 16'h3333;

    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset outputs", {6'd0, drp_dout, drp_ready, drp_err, busy, eoc, channel, ot}, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 7'h48, 16'h0, rd, lat);
    checkOutput("rd48 latency", lat, 4);
    checkOutput("rd48 data", rd, 16'h4701);
    applyStimulus(1'b0, 7'h7F, 16'h0, rd, lat);
    checkOutput("rd7F data", rd, 16'h0000);
    applyStimulus(1'b1, 7'h00, 16'h1234, rd, lat);
    applyStimulus(1'b0, 7'h00, 16'h0, rd, lat);
    checkOutput("rd00 read-only", rd, 16'h0000);
    applyStimulus(1'b1, 7'h4E, 16'hBEEF, rd, lat);
    applyStimulus(1'b0, 7'h4E, 16'h0, rd, lat);
    checkOutput("rd4E data", rd, 16'hBEEF);

    // Overlapping request two cycles after the first.
    @(negedge clk); drp_en = 1'b1; drp_we = 1'b0; drp_addr = 7'h40;
    @(negedge clk); drp_en = 1'b0;
    @(negedge clk); drp_en = 1'b1; drp_addr = 7'h41;
    @(negedge clk); drp_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (drp_ready) cnt++;
      @(negedge clk);
    end
    checkOutput("ready count overlap", cnt, 1);
    checkOutput("err sticky", drp_err, 1);

    // Reset while a read is pending.
    @(negedge clk); drp_en = 1'b1; drp_addr = 7'h40;
    @(negedge clk); drp_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (drp_ready) cnt++;
      @(negedge clk);
    end
    checkOutput("ready after rst", cnt, 0);
    checkOutput("err cleared", drp_err, 0);

    for (int i = 0; i < 5; i++) begin
      waitEoc(-1, got);
      checkOutput("scan order", got, expOrder[i]);
    end
    waitEoc(-1, got);
    checkOutput("scan order ch1", got, 1);
    applyStimulus(1'b1, 7'h48, 16'h0500, rd, lat);
    for (int i = 0; i < 4; i++) begin
      waitEoc(-1, got);
      checkOutput("scan order new mask", got, expAfter[i]);
    end

    sVccint = 16'h5AB7;
    applyStimulus(1'b1, 7'h48, 16'h0200, rd, lat);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    cnt = 0;
    while (busy && cnt < 100) begin @(negedge clk); cnt++; end
    checkOutput("busy width", cnt, 26);
    waitEoc(1, got);
    checkOutput("eoc ch1", got, 1);
    applyStimulus(1'b0, 7'h01, 16'h0, rd, lat);
    checkOutput("rd01 status", rd, 16'h5AB0);

    sTemp = 16'hDE00;
    applyStimulus(1'b1, 7'h48, 16'h0100, rd, lat);
    waitEoc(0, got);
    @(negedge clk);
    checkOutput("ot set DE00", ot, 1);
    sTemp = 16'hB000;
    waitEoc(0, got);
    @(negedge clk);
    checkOutput("ot hold B000", ot, 1);
    sTemp = 16'hA000;
    waitEoc(0, got);
    @(negedge clk);
    checkOutput("ot clear A000", ot, 0);

    applyStimulus(1'b1, 7'h48, 16'h4701, rd, lat);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drp_en = ($urandom_range(0, 3) == 0);
      drp_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       drp_addr = 7'h41;
        1:       drp_addr = 7'h48;
        2:       drp_addr = 7'h53;
        3:       drp_addr = 7'h57;
        4:       drp_addr = 7'($urandom_range(0, 6));
        default: drp_addr = 7'($urandom_range(0, 127));
      endcase
      drp_din = 16'($urandom);
      if (drp_addr == 7'h41 && $urandom_range(0, 3) != 0) drp_din[15:12] = 4'h2;
      if ($urandom_range(0, 15) == 0) sTemp = 16'($urandom);
      if ($urandom_range(0, 15) == 0) sVccint = 16'($urandom);
      if ($urandom_range(0, 15) == 0) sVccaux = 16'($urandom);
      if ($urandom_range(0, 15) == 0) sBram = 16'($urandom);
      rst = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    drp_en = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
